tournament_predictor: RTL and testbench

Parametrised next-generation fetch-stage branch predictor for the core. It combines a tagged branch target buffer with three counter tables: a per-PC local table, a gshare global table and a chooser, and an optional return address stack. Lookup uses `next_pc` and produces a prediction one cycle later against `pc`. Training uses branches resolved in EX.

---
 rtl/tournament_predictor_if.sv | 27 ++
 rtl/tournament_predictor.sv | 177 +++++++++++++++++
 tb/tb_tournament_predictor.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tournament_predictor_if.sv
// rtl/tournament_predictor_if.sv - fetch lookup and EX update bus of the tournament branch predictor
// master: fetch/EX side driving lookups and resolved branches; slave: the predictor.
interface tournament_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  predict_hit;
  logic                  predict_taken;
  logic [ADDR_WIDTH-1:0] predict_target_pc;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic [ADDR_WIDTH-1:0] upd_target;
  logic                  upd_taken;
  logic                  upd_is_call;
  logic                  upd_is_ret;

  modport master (
    output next_pc, pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_call, upd_is_ret,
    input  predict_hit, predict_taken, predict_target_pc
  );

  modport slave (
    input  next_pc, pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_call, upd_is_ret,
    output predict_hit, predict_taken, predict_target_pc
  );
endinterface

// File: rtl/tournament_predictor.sv
// rtl/tournament_predictor.sv - tagged BTB with local/gshare/chooser tournament direction predictor
// Optional return address stack is built when BP_RAS_EN is defined.
module tournament_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRY_NUM  = 256,
  parameter int CNT_WIDTH  = 2,
  parameter int GHR_WIDTH  = 8,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  tournament_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int MSB   = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] WNT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t cnt_step(input cnt_t c, input logic up);
    cnt_t r;
    r = c;
    if (up) begin
      if (c != '1) r = c + 1'b1;
    end else if (c != '0) begin
      r = c - 1'b1;
    end
    return r;
  endfunction

  logic                  valid_mem   [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] tag_mem     [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] tgt_mem     [ENTRY_NUM];
  logic                  is_ret_mem  [ENTRY_NUM];
  cnt_t                  local_mem   [ENTRY_NUM];
  cnt_t                  global_mem  [ENTRY_NUM];
  cnt_t                  chooser_mem [ENTRY_NUM];

  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] tag_q;
  logic [ADDR_WIDTH-1:0] target_q;
  logic                  is_ret_q;
  cnt_t                  loc_q, glb_q, cho_q;

  idx_t lk_idx, lk_gidx, up_idx, up_gidx;
  cnt_t loc_old, glb_old, cho_old;

  assign lk_idx  = bp.next_pc[IDX_W+1:2];
  assign lk_gidx = lk_idx ^ idx_t'(ghr_q);
  assign up_idx  = bp.upd_pc[IDX_W+1:2];
  assign up_gidx = up_idx ^ idx_t'(ghr_q);

  assign loc_old = local_mem[up_idx];
  assign glb_old = global_mem[up_gidx];
  assign cho_old = chooser_mem[up_idx];
  assign ghr_d   = {ghr_q[GHR_WIDTH-2:0], bp.upd_taken};

  // Chooser only learns when the two components disagree.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_mem[i]   <= 1'b0;
        local_mem[i]   <= WNT;
        global_mem[i]  <= WNT;
        chooser_mem[i] <= WNT;
      end
    end else if (bp.upd_valid) begin
      valid_mem[up_idx]   <= 1'b1;
      local_mem[up_idx]   <= cnt_step(loc_old, bp.upd_taken);
      global_mem[up_gidx] <= cnt_step(glb_old, bp.upd_taken);
      if (loc_old[MSB] != glb_old[MSB])
        chooser_mem[up_idx] <= cnt_step(cho_old, glb_old[MSB] == bp.upd_taken);
      ghr_q <= ghr_d;
    end
  end

  // Payload fields are qualified by valid_mem, so they need no reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rstn && bp.upd_valid) begin
      tag_mem[up_idx]    <= bp.upd_pc;
      tgt_mem[up_idx]    <= bp.upd_target;
      is_ret_mem[up_idx] <= bp.upd_is_ret;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      is_ret_q <= 1'b0;
      loc_q    <= '0;
      glb_q    <= '0;
      cho_q    <= '0;
    end else begin
      valid_q  <= valid_mem[lk_idx];
      tag_q    <= tag_mem[lk_idx];
      target_q <= tgt_mem[lk_idx];
      is_ret_q <= is_ret_mem[lk_idx];
      loc_q    <= local_mem[lk_idx];
      glb_q    <= global_mem[lk_gidx];
      cho_q    <= chooser_mem[lk_idx];
    end
  end

  logic hit, dir;
  assign hit = valid_q && (tag_q == bp.pc);
  assign dir = cho_q[MSB] ? glb_q[MSB] : loc_q[MSB];

  assign bp.predict_hit   = hit;
  assign bp.predict_taken = hit && dir;

`ifdef BP_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int RCW   = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ras_top_q, ras_top_d, ras_wr_ptr;
  logic [RCW-1:0]        ras_cnt_q, ras_cnt_d;
  logic                  ras_wr;
  logic [ADDR_WIDTH-1:0] ret_addr;

  assign ret_addr = bp.upd_pc + ADDR_WIDTH'(4);

  // Circular stack: a push on a full stack silently overwrites the oldest slot.
  always_comb begin
    ras_top_d  = ras_top_q;
    ras_cnt_d  = ras_cnt_q;
    ras_wr     = 1'b0;
    ras_wr_ptr = ras_top_q;
    if (bp.upd_valid) begin
      if (bp.upd_is_call && (!bp.upd_is_ret || ras_cnt_q == '0)) begin
        ras_top_d  = ras_top_q + 1'b1;
        ras_wr     = 1'b1;
        ras_wr_ptr = ras_top_q + 1'b1;
        if (ras_cnt_q != RCW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
      end else if (bp.upd_is_call && bp.upd_is_ret) begin
        ras_wr = 1'b1;
      end else if (bp.upd_is_ret && ras_cnt_q != '0) begin
        ras_top_d = ras_top_q - 1'b1;
        ras_cnt_d = ras_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rstn && ras_wr) ras_mem[ras_wr_ptr] <= ret_addr;
  end

  assign bp.predict_target_pc = (is_ret_q && hit && ras_cnt_q != '0) ? ras_mem[ras_top_q] : target_q;

  logic unused_sink;
  assign unused_sink = ^bp.next_pc;
`else
  localparam logic [31:0] RAS_DEPTH_U = RAS_DEPTH;

  assign bp.predict_target_pc = target_q;

  logic unused_sink;
  assign unused_sink = ^{bp.next_pc, bp.upd_is_call, bp.upd_is_ret, RAS_DEPTH_U[0]};
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// tb/tb_tournament_predictor.sv - directed self-checking bench for tournament_predictor
// Built with GHR_WIDTH=2 and RAS_DEPTH=2; RAS expectations follow BP_RAS_EN.
module tb_tournament_predictor;
  logic cpu_clk;
  logic cpu_rstn;
  int   n_cmp;
  int   n_fail;

  tournament_predictor_if #(.ADDR_WIDTH(32)) bp_if ();

  tournament_predictor #(
    .ADDR_WIDTH(32),
    .ENTRY_NUM (256),
    .CNT_WIDTH (2),
    .GHR_WIDTH (2),
    .RAS_DEPTH (2)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rstn(cpu_rstn),
    .bp      (bp_if.slave)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bp_if.upd_valid   = 1'b0;
    bp_if.upd_pc      = '0;
    bp_if.upd_target  = '0;
    bp_if.upd_taken   = 1'b0;
    bp_if.upd_is_call = 1'b0;
    bp_if.upd_is_ret  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bp_if.next_pc = '0;
    bp_if.pc      = '0;
    cpu_rstn = 1'b0;
    tick();
    tick();
    cpu_rstn = 1'b1;
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk,
                     input logic call, input logic ret);
    bp_if.upd_valid   = 1'b1;
    bp_if.upd_pc      = a;
    bp_if.upd_target  = t;
    bp_if.upd_taken   = tk;
    bp_if.upd_is_call = call;
    bp_if.upd_is_ret  = ret;
    tick();
    idle_inputs();
  endtask

  task automatic lookup(input logic [31:0] a);
    bp_if.next_pc = a;
    tick();
    bp_if.pc = a;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bp_if.next_pc = 32'h100;
    bp_if.pc      = 32'h100;
    cpu_rstn = 1'b0;
    tick();
    n_cmp++;
    if (bp_if.predict_hit !== 1'b0) begin
      n_fail++; $display("FAIL rst_hit: got %0b want 0", bp_if.predict_hit);
    end
    cpu_rstn = 1'b1;
    lookup(32'h100);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b0) begin
      n_fail++; $display("FAIL rst_lookup_hit: got %0b want 0", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL rst_lookup_taken: got %0b want 0", bp_if.predict_taken);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h0) begin
      n_fail++; $display("FAIL rst_lookup_target: got %h want 0", bp_if.predict_target_pc);
    end
  endtask

  task automatic test_train_taken();
    do_reset();
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b1) begin
      n_fail++; $display("FAIL train_hit: got %0b want 1", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL train_taken: got %0b want 1", bp_if.predict_taken);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h80) begin
      n_fail++; $display("FAIL train_target: got %h want 80", bp_if.predict_target_pc);
    end
    // Saturated local counter: one more T then one N leaves it at 2 (still taken).
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 1'b0);
    lookup(32'h100);
    n_cmp++;
    if (bp_if.predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL train_saturate: got %0b want 1", bp_if.predict_taken);
    end
  endtask

  task automatic test_read_before_write();
    bp_if.next_pc     = 32'h500;
    bp_if.upd_valid   = 1'b1;
    bp_if.upd_pc      = 32'h500;
    bp_if.upd_target  = 32'h600;
    bp_if.upd_taken   = 1'b1;
    tick();
    idle_inputs();
    bp_if.pc = 32'h500;
    #1;
    n_cmp++;
    if (bp_if.predict_hit !== 1'b0) begin
      n_fail++; $display("FAIL rbw_old_hit: got %0b want 0", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h80) begin
      n_fail++; $display("FAIL rbw_old_target: got %h want 80", bp_if.predict_target_pc);
    end
    lookup(32'h500);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b1) begin
      n_fail++; $display("FAIL rbw_new_hit: got %0b want 1", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h600) begin
      n_fail++; $display("FAIL rbw_new_target: got %h want 600", bp_if.predict_target_pc);
    end
  endtask

  task automatic test_alternating();
    logic exp_t;
    do_reset();
    bp_if.pc = 32'h200;
    for (int i = 0; i < 16; i++) begin
      exp_t = (i % 2 == 0);
      bp_if.next_pc    = 32'h200;
      bp_if.upd_valid  = 1'b1;
      bp_if.upd_pc     = 32'h200;
      bp_if.upd_target = 32'h240;
      bp_if.upd_taken  = exp_t;
      tick();
      idle_inputs();
      #1;
      if (i >= 8) begin
        n_cmp++;
        if (bp_if.predict_taken !== exp_t) begin
          n_fail++; $display("FAIL alt_pred[%0d]: got %0b want %0b", i, bp_if.predict_taken, exp_t);
        end
      end
    end
  endtask

  task automatic test_ras();
    logic [31:0] exp_a, exp_b;
`ifdef BP_RAS_EN
    exp_a = 32'h34;
    exp_b = 32'h24;
`else
    exp_a = 32'h900;
    exp_b = 32'h900;
`endif
    do_reset();
    upd(32'h500, 32'h900, 1'b1, 1'b0, 1'b1);
    upd(32'h10, 32'h1000, 1'b1, 1'b1, 1'b0);
    upd(32'h20, 32'h1000, 1'b1, 1'b1, 1'b0);
    upd(32'h30, 32'h1000, 1'b1, 1'b1, 1'b0);
    lookup(32'h500);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b1) begin
      n_fail++; $display("FAIL ras_hit: got %0b want 1", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== exp_a) begin
      n_fail++; $display("FAIL ras_first: got %h want %h", bp_if.predict_target_pc, exp_a);
    end
    upd(32'h500, 32'h900, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (bp_if.predict_target_pc !== exp_b) begin
      n_fail++; $display("FAIL ras_second: got %h want %h", bp_if.predict_target_pc, exp_b);
    end
    upd(32'h500, 32'h900, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h900) begin
      n_fail++; $display("FAIL ras_empty: got %h want 900", bp_if.predict_target_pc);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup(32'h100);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_hit: got %0b want 1", bp_if.predict_hit);
    end
    bp_if.upd_valid  = 1'b1;
    bp_if.upd_pc     = 32'h100;
    bp_if.upd_target = 32'h300;
    bp_if.upd_taken  = 1'b1;
    @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    #1;
    n_cmp++;
    if (bp_if.predict_hit !== 1'b0) begin
      n_fail++; $display("FAIL mid_hit: got %0b want 0", bp_if.predict_hit);
    end
    n_cmp++;
    if (bp_if.predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL mid_taken: got %0b want 0", bp_if.predict_taken);
    end
    n_cmp++;
    if (bp_if.predict_target_pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_target: got %h want 0", bp_if.predict_target_pc);
    end
    tick();
    idle_inputs();
    cpu_rstn = 1'b1;
    lookup(32'h100);
    n_cmp++;
    if (bp_if.predict_hit !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_hit: got %0b want 0", bp_if.predict_hit);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cpu_rstn = 1'b0;
    idle_inputs();
    bp_if.next_pc = '0;
    bp_if.pc      = '0;
    test_reset();
    test_train_taken();
    test_read_before_write();
    test_alternating();
    test_ras();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
